// File: rtl/image_pass_if.sv
// image_pass_if: control/handshake bundle between the pass scheduler and the
// controller plus the per-pass image engines.
//
// Signals:
//   start, abort, pass_en   run control (driven by the controller)
//   busy, all_done          run status
//   gray_done, compress_done, encode_done  per-pass completion levels
//   pass_id, sweep, pass_start             active pass selection and start pulse
//   row, col, px_valid, px_ready           pixel address with valid/ready handshake
//
// Modports:
//   master  the scheduler side
//   slave   the controller/engine side
interface image_pass_if #(
  parameter int unsigned ADDR_W = 6
);
  logic              start;
  logic              abort;
  logic [2:0]        pass_en;
  logic              busy;
  logic [1:0]        pass_id;
  logic              sweep;
  logic              pass_start;
  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] col;
  logic              px_valid;
  logic              px_ready;
  logic              gray_done;
  logic              compress_done;
  logic              encode_done;
  logic              all_done;

  modport master (
    input  start, abort, pass_en, px_ready,
    output busy, pass_id, sweep, pass_start, row, col, px_valid,
           gray_done, compress_done, encode_done, all_done
  );

  modport slave (
    output start, abort, pass_en, px_ready,
    input  busy, pass_id, sweep, pass_start, row, col, px_valid,
           gray_done, compress_done, encode_done, all_done
  );
endinterface

// File: rtl/image_pass_scheduler.sv
// image_pass_scheduler: runs the enabled image passes (gray, compress, encode)
// in order, owning the shared pixel address port and stepping the active
// engine one pixel per accepted valid/ready handshake. Compress is scanned
// twice (statistics sweep, then reconstruct sweep).
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    image_pass_if.master: start/abort/pass_en/px_ready in; busy, pass_id,
//          sweep, pass_start, row, col, px_valid, done flags, all_done out
//
// Build option:
//   IMG_BLOCK_SCAN_EN  when defined, both compress sweeps walk the image in
//                      4x4 blocks (raster inside a block); otherwise every pass
//                      is raster order and the block-order mux is absent.
//
// All outputs are registered: next-state values are computed combinationally
// and the visible outputs are decoded from the next state into flops.
module image_pass_scheduler #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  image_pass_if.master  bus
);

  localparam int unsigned IdxW = 2 * ADDR_W;
  localparam logic [IdxW-1:0] IdxLast = '1;
  localparam logic [IdxW-1:0] IdxOne  = IdxW'(1);

  typedef enum logic [1:0] {StIdle, StLoad, StScan, StFinish} state_e;

  state_e            state_q, state_d;
  logic [2:0]        mask_q, mask_d;
  logic [1:0]        pass_id_q, pass_id_d;
  logic              sweep_q, sweep_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [2:0]        done_q, done_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic              busy_q, pass_start_q, px_valid_q, all_done_q;
  logic [2:0]        nxt;

  // Lowest enabled pass with id >= lo, returned as {found, id}.
  function automatic logic [2:0] pick_pass(input logic [2:0] mask, input logic [1:0] lo);
    logic [2:0] res;
    res = 3'b000;
    for (int i = 2; i >= 0; i--) begin
      if (mask[i] && (i >= int'(lo))) res = {1'b1, 2'(i)};
    end
    return res;
  endfunction

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    pass_id_d = pass_id_q;
    sweep_d   = sweep_q;
    idx_d     = idx_q;
    done_d    = done_q;
    nxt       = 3'b000;

    if (bus.abort) begin
      state_d = StIdle;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            mask_d = bus.pass_en;
            done_d = 3'b000;
            nxt    = pick_pass(bus.pass_en, 2'd0);
            idx_d  = '0;
            if (nxt[2]) begin
              state_d   = StLoad;
              pass_id_d = nxt[1:0];
              sweep_d   = 1'b0;
            end else begin
              state_d = StFinish;
            end
          end
        end
        StLoad: begin
          idx_d   = '0;
          state_d = StScan;
        end
        StScan: begin
          // px_valid is always high in SCAN, so px_ready alone is the accept.
          if (bus.px_ready) begin
            if (idx_q != IdxLast) begin
              idx_d = idx_q + IdxOne;
            end else begin
              idx_d = '0;
              if (pass_id_q == 2'd1 && !sweep_q) begin
                sweep_d = 1'b1;
                state_d = StLoad;
              end else begin
                done_d  = done_q | (3'b001 << pass_id_q);
                sweep_d = 1'b0;
                // pass_id_q + 1 wraps to 3 after encode, which matches nothing.
                nxt     = pick_pass(mask_q, pass_id_q + 2'd1);
                if (nxt[2]) begin
                  state_d   = StLoad;
                  pass_id_d = nxt[1:0];
                end else begin
                  state_d = StFinish;
                end
              end
            end
          end
        end
        StFinish: state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  // Pixel index to address.
  always_comb begin
    row_d = idx_d[IdxW-1:ADDR_W];
    col_d = idx_d[ADDR_W-1:0];
`ifdef IMG_BLOCK_SCAN_EN
    if (pass_id_d == 2'd1) begin
      row_d = {idx_d[IdxW-1:ADDR_W+2], idx_d[3:2]};
      col_d = {idx_d[ADDR_W+1:4], idx_d[1:0]};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      mask_q       <= 3'b000;
      pass_id_q    <= 2'd0;
      sweep_q      <= 1'b0;
      idx_q        <= '0;
      done_q       <= 3'b000;
      row_q        <= '0;
      col_q        <= '0;
      busy_q       <= 1'b0;
      pass_start_q <= 1'b0;
      px_valid_q   <= 1'b0;
      all_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      pass_id_q    <= pass_id_d;
      sweep_q      <= sweep_d;
      idx_q        <= idx_d;
      done_q       <= done_d;
      row_q        <= row_d;
      col_q        <= col_d;
      busy_q       <= (state_d != StIdle);
      pass_start_q <= (state_d == StLoad);
      px_valid_q   <= (state_d == StScan);
      all_done_q   <= (state_d == StFinish);
    end
  end

  assign bus.busy          = busy_q;
  assign bus.pass_id       = pass_id_q;
  assign bus.sweep         = sweep_q;
  assign bus.pass_start    = pass_start_q;
  assign bus.row           = row_q;
  assign bus.col           = col_q;
  assign bus.px_valid      = px_valid_q;
  assign bus.gray_done     = done_q[0];
  assign bus.compress_done = done_q[1];
  assign bus.encode_done   = done_q[2];
  assign bus.all_done      = all_done_q;

endmodule

// File: tb/tb_image_pass_scheduler.sv
// Self-checking bench for image_pass_scheduler. A pass-list model derived from
// the enable mask predicts every cycle of a run, including randomized
// px_ready stalls and stray start pulses while busy.
module tb_image_pass_scheduler;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   fin_cyc;

  image_pass_if #(.ADDR_W(6)) bus ();

  image_pass_scheduler #(.ADDR_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack(input logic b, input logic ps, input logic pv,
                                       input logic ad, input logic [2:0] dn, input logic sw,
                                       input logic [1:0] id, input logic [5:0] r,
                                       input logic [5:0] c);
    return {10'd0, b, ps, pv, ad, dn, sw, id, r, c};
  endfunction

  // Observed outputs; pass_id/sweep and row/col are masked where undefined.
  function automatic logic [31:0] status(input logic with_id, input logic with_addr);
    return pack(bus.busy, bus.pass_start, bus.px_valid, bus.all_done,
                {bus.encode_done, bus.compress_done, bus.gray_done},
                with_id ? bus.sweep : 1'b0, with_id ? bus.pass_id : 2'd0,
                with_addr ? bus.row : 6'd0, with_addr ? bus.col : 6'd0);
  endfunction

  // Expected {row, col} for the k-th pixel of pass p.
  function automatic logic [11:0] exp_addr(input int p, input int k);
    int r;
    int c;
    r = k / 64;
    c = k % 64;
`ifdef IMG_BLOCK_SCAN_EN
    if (p == 1) begin
      r = (k / 256) * 4 + (k % 16) / 4;
      c = ((k / 16) % 16) * 4 + k % 4;
    end
`endif
    return {6'(r), 6'(c)};
  endfunction

  // Called at a negedge with the DUT idle; drives start this cycle (cycle 0).
  task automatic run_check(input logic [2:0] mask, input int unsigned stall_pct,
                           output int fin);
    int p_q[$];
    int w_q[$];
    logic [2:0]  dn;
    logic [11:0] a;
    int cyc;
    int k;
    int guard;
    int p;
    int w;
    for (int i = 0; i < 3; i++) begin
      if (mask[i]) begin
        p_q.push_back(i);
        w_q.push_back(0);
        if (i == 1) begin
          p_q.push_back(1);
          w_q.push_back(1);
        end
      end
    end
    dn = 3'b000;
    bus.start   = 1'b1;
    bus.pass_en = mask;
    cyc = 0;
    for (int s = 0; s < p_q.size(); s++) begin
      p = p_q[s];
      w = w_q[s];
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
      check_eq("load", status(1'b1, 1'b0), pack(1, 1, 0, 0, dn, 1'(w), 2'(p), 6'd0, 6'd0));
      k = 0;
      guard = 0;
      while (k < 4096 && guard < 40000) begin
        @(negedge clk);
        cyc++;
        guard++;
        a = exp_addr(p, k);
        check_eq("scan", status(1'b1, 1'b1),
                 pack(1, 0, 1, 0, dn, 1'(w), 2'(p), a[11:6], a[5:0]));
        bus.px_ready = ($urandom_range(99) >= stall_pct);
        bus.start    = ($urandom_range(31) == 0);
        bus.pass_en  = 3'($urandom);
        if (bus.px_ready) k++;
      end
      if (k < 4096) check_eq("scan_timeout", 32'(k), 32'd4096);
      if (!(p == 1 && w == 0)) dn[p] = 1'b1;
    end
    @(negedge clk);
    cyc++;
    bus.start    = 1'b0;
    bus.px_ready = 1'b0;
    check_eq("finish", status(1'b0, 1'b0), pack(1, 0, 0, 1, dn, 0, 2'd0, 6'd0, 6'd0));
    fin = cyc;
    @(negedge clk);
    check_eq("idle", status(1'b0, 1'b0), pack(0, 0, 0, 0, dn, 0, 2'd0, 6'd0, 6'd0));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.pass_en  = 3'b000;
    bus.px_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_state", status(1'b1, 1'b1), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_reset", status(1'b1, 1'b1), 32'd0);

    // Gray only, ready tied high: all_done at cycle 4098.
    run_check(3'b001, 0, fin_cyc);
    check_eq("gray_fin_cycle", 32'(fin_cyc), 32'd4098);

    // All passes, ready tied high: all_done at cycle 16389.
    run_check(3'b111, 0, fin_cyc);
    check_eq("all_fin_cycle", 32'(fin_cyc), 32'd16389);

    // Abort at cycle 100 of gray.
    bus.start    = 1'b1;
    bus.pass_en  = 3'b001;
    bus.px_ready = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check_eq("abort", status(1'b0, 1'b0), pack(0, 0, 0, 0, 3'b000, 0, 2'd0, 6'd0, 6'd0));
    @(negedge clk);
    check_eq("abort_hold", status(1'b0, 1'b0), pack(0, 0, 0, 0, 3'b000, 0, 2'd0, 6'd0, 6'd0));

    // Abort beats start in IDLE.
    bus.start   = 1'b1;
    bus.abort   = 1'b1;
    bus.pass_en = 3'b111;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check_eq("abort_vs_start", status(1'b0, 1'b0),
             pack(0, 0, 0, 0, 3'b000, 0, 2'd0, 6'd0, 6'd0));
    @(negedge clk);
    check_eq("abort_vs_start2", status(1'b0, 1'b0),
             pack(0, 0, 0, 0, 3'b000, 0, 2'd0, 6'd0, 6'd0));

    // Restart after abort, with random stalls.
    run_check(3'b001, 30, fin_cyc);

    // Asynchronous reset mid-scan.
    bus.start    = 1'b1;
    bus.pass_en  = 3'b110;
    bus.px_ready = 1'b1;
    repeat (50) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    check_eq("pre_reset_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_eq("async_reset", status(1'b1, 1'b1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.px_ready = 1'b0;
    @(negedge clk);

    // Empty mask: FINISH straight away.
    run_check(3'b000, 0, fin_cyc);
    check_eq("empty_fin_cycle", 32'(fin_cyc), 32'd1);

    // Compress + encode with random stalls.
    run_check(3'b110, 20, fin_cyc);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/image_pass_scheduler.md
# image_pass_scheduler

Sequencer for the 64x64 image-processing datapath. It runs the enabled processing passes (grayscale, AMBTC compression, encode) strictly in order. For each pass it owns the single image address port (`row`/`col`) and steps the active engine one pixel at a time over a valid/ready handshake. It also generates the per-pass start pulses, done flags and a final completion pulse, so the pass engines contain no traversal logic of their own.

## Interface
Parameters:
- `ADDR_W`, 6, row/col width; image is 2^ADDR_W x 2^ADDR_W (fixed at 64x64 for this design).

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `abort`  in  1  cancel the run; highest priority.
- `pass_en`  in  3  pass enables: bit0 gray, bit1 compress, bit2 encode. Sampled with `start`.
- `busy`  out  1  high in every state except IDLE.
- `pass_id`  out  2  active pass: 0 gray, 1 compress, 2 encode.
- `sweep`  out  1  compress sub-scan: 0 = statistics, 1 = reconstruct. Always 0 for the other passes.
- `pass_start`  out  1  one-cycle pulse in LOAD.
- `row`, `col`  out  ADDR_W each  current pixel address.
- `px_valid`  out  1  address valid for the engine.
- `px_ready`  in  1  engine has finished the current pixel.
- `gray_done`, `compress_done`, `encode_done`  out  1  level flags, set on completion of the pass and cleared on an accepted `start`.
- `all_done`  out  1  one-cycle pulse in FINISH.

## Operation
- States: IDLE, LOAD, SCAN, FINISH.
- IDLE: when `start`=1, latch `pass_en` and clear all three done flags.
  - If the latched mask is nonzero, go to LOAD with the lowest enabled pass.
  - If the mask is 0, go to FINISH.
- LOAD: assert `pass_start`, set `pass_id`/`sweep`, clear the 12-bit pixel index `idx`, then go to SCAN.
- SCAN: assert `px_valid`. `idx` increments only on `px_valid && px_ready`.
  - Accept with `idx`≠4095: stay in SCAN.
  - Accept with `idx`=4095 during compress sweep 0: set `sweep`=1 and go to LOAD.
  - Any other final accept: set the pass's done flag. Go to LOAD for the next enabled pass, or to FINISH if none remain.
- FINISH: assert `all_done` for one cycle, then go to IDLE. Done flags hold until the next accepted `start`.
- Address mapping:
  - Raster order: `row`=idx[11:6], `col`=idx[5:0].
  - Block order (4x4 blocks, raster within a block): `row`={idx[11:8], idx[3:2]}, `col`={idx[7:4], idx[1:0]}.
- `start` while `busy`: ignored.
- `abort` in any state: go to IDLE next cycle with `px_valid`=0. No `all_done` pulse; done flags of already-completed passes are kept. `abort` and `start` together in IDLE: `abort` wins and the run does not begin.
- Reset: state IDLE; `busy`, `px_valid`, `pass_start`, `all_done`, all done flags, `sweep`, `pass_id`, `row`, `col`, `idx` all 0; latched mask 0.

## Timing
- Every output is registered.
- With `start` high at cycle 0: LOAD at cycle 1, first `px_valid` at cycle 2 with address (0,0).
- `row`/`col` stay stable while `px_valid`=1 and `px_ready`=0. A new address appears the cycle after an accept.
- A full pass with `px_ready` tied high takes 4096 SCAN cycles. Compress takes two sweeps, each preceded by its own LOAD cycle.
- A done flag rises in the cycle after the final accept, together with the next LOAD or FINISH.
- Between passes, `px_valid` is 0 for exactly one cycle (LOAD).

## Configuration
- `IMG_BLOCK_SCAN_EN` defined: both compress sweeps use block order. Gray and encode always use raster order.
- `IMG_BLOCK_SCAN_EN` undefined: every pass uses raster order, and the block-order mux is not built.

## Test plan
- `pass_en`=3'b001, `px_ready`=1, `start` at cycle 0:
  - `pass_start` at cycle 1; `px_valid` on cycles 2..4097; last address (63,63).
  - At cycle 4098: `gray_done`=1 and `all_done` pulses. At cycle 4099: `busy`=0.
- `pass_en`=3'b111, `px_ready`=1:
  - `gray_done` at cycle 4098, `compress_done` at 12292, `encode_done` and `all_done` at 16389.
  - `sweep`=1 only on cycles 8195..12291.
- `IMG_BLOCK_SCAN_EN` defined, compress only: accepts 0..4 give (row,col) = (0,0), (0,1), (0,2), (0,3), (1,0); accept 16 gives (0,4).
- Random `px_ready` stalls: `row`/`col` are held while `px_ready`=0, with exactly 4096 accepts per sweep and no address skipped or repeated.
- `abort` at cycle 100 of the gray pass: next cycle IDLE with `busy`=0 and `px_valid`=0, no `all_done`, `gray_done`=0. A following `start` restarts from (0,0).
- Edge cases:
  - `start` with `pass_en`=0: `all_done` at cycle 1 and no `px_valid` at any point.
  - `start` pulsed while `busy`: no effect.
  - `rst_n` low mid-scan: all outputs 0 immediately, without waiting for a clock edge.
